// File: rtl/maze_vga_renderer.sv
// Scans the 64x64 carved maze image out as 640x480@60 VGA through a 3-stage pixel pipeline.
// Optional cursor highlight is enabled by defining MAZE_CURSOR_EN.
module maze_vga_renderer #(
  parameter int CELL_PX = 7,
  parameter int X_OFF   = 96,
  parameter int Y_OFF   = 16,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8191:0] maze_data,
  input  logic          maze_valid,
`ifdef MAZE_CURSOR_EN
  input  logic [5:0]    cursor_x,
  input  logic [5:0]    cursor_y,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic [2:0]    rgb,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_PRE    = HW'(X_OFF - 1);
  localparam logic [HW-1:0] X_START  = HW'(X_OFF);
  localparam logic [HW-1:0] X_END    = HW'(X_OFF + 64 * CELL_PX);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_PRE    = VW'(Y_OFF - 1);
  localparam logic [VW-1:0] Y_START  = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_END    = VW'(Y_OFF + 64 * CELL_PX);
  localparam logic [SW-1:0] SUB_MAX  = SW'(CELL_PX - 1);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [5:0]    cell_x_q, cell_x_d, cell_y_q, cell_y_d;

  logic [1:0]    s1_code_q, s1_code_d;
  logic          s1_vis_q, s1_vis_d;
  logic          s1_in_maze_q, s1_in_maze_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_hs_n_q, s1_hs_n_d;
  logic          s1_vs_n_q, s1_vs_n_d;
  logic          s1_first_q, s1_first_d;

  logic [2:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;

  logic          h_wrap, in_x, in_y;

`ifdef MAZE_CURSOR_EN
  logic [5:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic          s1_cursor_q, s1_cursor_d;
`endif

  // S0: raster counters and divider-free cell addressing; cells saturate at 63.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    in_x     = (hcount_q >= X_START) && (hcount_q < X_END);
    in_y     = (vcount_q >= Y_START) && (vcount_q < Y_END);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    sub_x_d  = sub_x_q;
    cell_x_d = cell_x_q;
    sub_y_d  = sub_y_q;
    cell_y_d = cell_y_q;

    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end

    if (hcount_q == X_PRE) begin
      sub_x_d  = '0;
      cell_x_d = '0;
    end else if (in_x) begin
      if (sub_x_q == SUB_MAX) begin
        sub_x_d = '0;
        if (cell_x_q != 6'd63) cell_x_d = cell_x_q + 1'b1;
      end else begin
        sub_x_d = sub_x_q + 1'b1;
      end
    end

    if (h_wrap) begin
      if (vcount_q == Y_PRE) begin
        sub_y_d  = '0;
        cell_y_d = '0;
      end else if (in_y) begin
        if (sub_y_q == SUB_MAX) begin
          sub_y_d = '0;
          if (cell_y_q != 6'd63) cell_y_d = cell_y_q + 1'b1;
        end else begin
          sub_y_d = sub_y_q + 1'b1;
        end
      end
    end
  end

  // S1: fetch the cell code live from the carver bus and delay the raster flags.
  always_comb begin
    s1_code_d    = maze_data[{cell_y_q, cell_x_q, 1'b0} +: 2];
    s1_vis_d     = (hcount_q < H_VIS_L) && (vcount_q < V_VIS_L);
    s1_in_maze_d = in_x && in_y;
    s1_valid_d   = maze_valid;
    s1_hs_n_d    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    s1_vs_n_d    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    s1_first_d   = (hcount_q == '0) && (vcount_q == '0);
`ifdef MAZE_CURSOR_EN
    cur_x_d      = frame_start_q ? cursor_x : cur_x_q;
    cur_y_d      = frame_start_q ? cursor_y : cur_y_q;
    s1_cursor_d  = (cell_x_q == cur_x_q) && (cell_y_q == cur_y_q);
`endif
  end

  // S2: colour map in priority order blank > border > invalid maze > cursor > cell code.
  always_comb begin
    rgb_d         = 3'b000;
    hsync_d       = s1_hs_n_q;
    vsync_d       = s1_vs_n_q;
    frame_start_d = s1_first_q;
    if (!s1_vis_q) begin
      rgb_d = 3'b000;
    end else if (!s1_in_maze_q) begin
      rgb_d = 3'b010;
    end else if (!s1_valid_q) begin
      rgb_d = 3'b000;
`ifdef MAZE_CURSOR_EN
    end else if (s1_cursor_q) begin
      rgb_d = 3'b110;
`endif
    end else begin
      case (s1_code_q)
        2'b11:   rgb_d = 3'b111;
        2'b01:   rgb_d = 3'b001;
        2'b10:   rgb_d = 3'b100;
        default: rgb_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      sub_x_q       <= '0;
      cell_x_q      <= '0;
      sub_y_q       <= '0;
      cell_y_q      <= '0;
      s1_code_q     <= 2'b00;
      s1_vis_q      <= 1'b0;
      s1_in_maze_q  <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_hs_n_q     <= 1'b1;
      s1_vs_n_q     <= 1'b1;
      s1_first_q    <= 1'b0;
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef MAZE_CURSOR_EN
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      s1_cursor_q   <= 1'b0;
`endif
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sub_x_q       <= sub_x_d;
      cell_x_q      <= cell_x_d;
      sub_y_q       <= sub_y_d;
      cell_y_q      <= cell_y_d;
      s1_code_q     <= s1_code_d;
      s1_vis_q      <= s1_vis_d;
      s1_in_maze_q  <= s1_in_maze_d;
      s1_valid_q    <= s1_valid_d;
      s1_hs_n_q     <= s1_hs_n_d;
      s1_vs_n_q     <= s1_vs_n_d;
      s1_first_q    <= s1_first_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef MAZE_CURSOR_EN
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      s1_cursor_q   <= s1_cursor_d;
`endif
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_maze_vga_renderer.sv
// Self-checking bench for maze_vga_renderer. The raster is shrunk through the module
// parameters (cell size 2, short porches) so that two whole frames fit in a short run.
module tb_maze_vga_renderer;

  localparam int CELL_PX = 2;
  localparam int X_OFF   = 8;
  localparam int Y_OFF   = 4;
  localparam int H_VIS   = 144;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 6;
  localparam int H_BP    = 2;
  localparam int V_VIS   = 136;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int MAZE_PX = 64 * CELL_PX;
`ifdef MAZE_CURSOR_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [8191:0] maze_data = '0;
  logic          maze_valid = 1'b0;
  logic          hsync, vsync, frame_start;
  logic [2:0]    rgb;
  logic [5:0]    mcur_x = '0;
  logic [5:0]    mcur_y = '0;
`ifdef MAZE_CURSOR_EN
  logic [5:0]    cursor_x = 6'd30;
  logic [5:0]    cursor_y = 6'd2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [8191:0] snap1_data, snap2_data;
  logic          snap1_valid, snap2_valid;

  maze_vga_renderer #(
    .CELL_PX(CELL_PX), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .maze_data(maze_data),
    .maze_valid(maze_valid),
`ifdef MAZE_CURSOR_EN
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
`endif
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the pixel shown on the outputs is cyc-2.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Inputs as seen at the clock that fetches the cell code for the displayed pixel.
  always @(posedge clk) begin
    snap1_data  <= maze_data;
    snap2_data  <= snap1_data;
    snap1_valid <= maze_valid;
    snap2_valid <= snap1_valid;
  end

`ifdef MAZE_CURSOR_EN
  always @(negedge clk) begin
    if (cyc >= 2 && ((cyc - 2) % FRAME) == 0) begin
      mcur_x <= cursor_x;
      mcur_y <= cursor_y;
    end
  end
`endif

  // Expected {rgb, hsync, vsync, frame_start} for the output after clock c.
  function automatic logic [5:0] model_out(input int c, input logic [8191:0] d, input logic v,
                                           input logic [5:0] kx, input logic [5:0] ky);
    int p, x, y, cx, cy;
    logic [2:0] col;
    logic [1:0] code;
    logic hs, vs, fs;
    if (c < 2) return 6'b000_110;
    p  = (c - 2) % FRAME;
    x  = p % H_TOTAL;
    y  = p / H_TOTAL;
    hs = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
    vs = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
    fs = (p == 0);
    if (x >= H_VIS || y >= V_VIS) col = 3'b000;
    else if (x < X_OFF || x >= X_OFF + MAZE_PX || y < Y_OFF || y >= Y_OFF + MAZE_PX) col = 3'b010;
    else if (!v) col = 3'b000;
    else begin
      cx   = (x - X_OFF) / CELL_PX;
      cy   = (y - Y_OFF) / CELL_PX;
      code = d[cy * 128 + cx * 2 +: 2];
      if (CURSOR_ON && cx == int'(kx) && cy == int'(ky)) col = 3'b110;
      else if (code == 2'b11) col = 3'b111;
      else if (code == 2'b01) col = 3'b001;
      else if (code == 2'b10) col = 3'b100;
      else col = 3'b000;
    end
    return {col, hs, vs, fs};
  endfunction

  task automatic set_cell(input int cx, input int cy, input logic [1:0] code);
    maze_data[cy * 128 + cx * 2 +: 2] = code;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) maze_data[i * 32 +: 32] = $urandom();
    set_cell(0, 0, 2'b11);
    set_cell(1, 0, 2'b00);
    set_cell(0, 1, 2'b00);
    set_cell(5, 7, 2'b10);
    set_cell(63, 63, 2'b01);
    maze_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rgb !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_rgb got=%b exp=000", rgb); end
    n_checks++;
    if (hsync !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_hsync got=%b exp=1", hsync); end
    n_checks++;
    if (vsync !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_vsync got=%b exp=1", vsync); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
    reset = 1'b0;
  endtask

  task automatic test_frames();
    int p, x, y, cx, cy;
    int fs_n = 0, fs_c0 = -1, fs_c1 = -1;
    int hs_low = 0, hs_first = -1;
    int vs_low = 0, vs_first = -1, vs_last = -1;
    logic [5:0] got, exp;
    $display("[TB] two-frame scan");
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      @(negedge clk);
      exp = model_out(cyc, snap2_data, snap2_valid, mcur_x, mcur_y);
      got = {rgb, hsync, vsync, frame_start};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL scan cyc=%0d got rgb,hs,vs,fs=%b exp=%b", cyc, got, exp);
      end
      if (cyc >= 2) begin
        p = cyc - 2;
        x = p % H_TOTAL;
        y = (p / H_TOTAL) % V_TOTAL;
        if (frame_start === 1'b1) begin
          if (fs_n == 0) fs_c0 = cyc;
          else if (fs_n == 1) fs_c1 = cyc;
          fs_n++;
        end
        if (p < FRAME) begin
          if (y == 3 && hsync === 1'b0) begin
            if (hs_first < 0) hs_first = x;
            hs_low++;
          end
          if (vsync === 1'b0) begin
            if (vs_first < 0) vs_first = y;
            vs_last = y;
            vs_low++;
          end
          if (x >= X_OFF && x < X_OFF + CELL_PX && y >= Y_OFF && y < Y_OFF + CELL_PX) begin
            n_checks++;
            if (rgb !== 3'b111) begin n_fail++; $display("[TB] FAIL cell00_path x=%0d y=%0d got=%b exp=111", x, y, rgb); end
          end
          if (x == X_OFF + CELL_PX && y == Y_OFF) begin
            n_checks++;
            if (rgb !== 3'b000) begin n_fail++; $display("[TB] FAIL cell10_out got=%b exp=000", rgb); end
          end
          if (x == X_OFF - 1 && y == Y_OFF) begin
            n_checks++;
            if (rgb !== 3'b010) begin n_fail++; $display("[TB] FAIL left_border got=%b exp=010", rgb); end
          end
          if (x == X_OFF + 5 * CELL_PX && y == Y_OFF + 7 * CELL_PX) begin
            n_checks++;
            if (rgb !== 3'b100) begin n_fail++; $display("[TB] FAIL cell57_frontier got=%b exp=100", rgb); end
          end
          if (x == X_OFF + 63 * CELL_PX && y == Y_OFF + 63 * CELL_PX) begin
            n_checks++;
            if (rgb !== 3'b001) begin n_fail++; $display("[TB] FAIL cell6363_wall got=%b exp=001", rgb); end
          end
          if (x == X_OFF + MAZE_PX && y == Y_OFF + MAZE_PX) begin
            n_checks++;
            if (rgb !== 3'b010) begin n_fail++; $display("[TB] FAIL past_maze_border got=%b exp=010", rgb); end
          end
        end else begin
          if (x == X_OFF + 10 && y == Y_OFF + 10) begin
            n_checks++;
            if (rgb !== 3'b000) begin n_fail++; $display("[TB] FAIL invalid_maze got=%b exp=000", rgb); end
          end
          if (x == X_OFF - 1 && y == Y_OFF + 10) begin
            n_checks++;
            if (rgb !== 3'b010) begin n_fail++; $display("[TB] FAIL invalid_border got=%b exp=010", rgb); end
          end
          if (x == H_VIS && y == Y_OFF + 10) begin
            n_checks++;
            if (rgb !== 3'b000) begin n_fail++; $display("[TB] FAIL hblank got=%b exp=000", rgb); end
          end
        end
        // Live data changes mid-frame, then valid drop, then all-path maze for frame 1.
        if (p < FRAME && y >= Y_OFF + 20 && y < Y_OFF + 120 && $urandom_range(0, 49) == 0) begin
          cx = $urandom_range(0, 63);
          cy = $urandom_range(10, 60);
          set_cell(cx, cy, 2'($urandom_range(0, 3)));
        end
        if (p == (Y_OFF + 127) * H_TOTAL + X_OFF + 40) maze_valid = 1'b0;
        if (p == (V_VIS - 1) * H_TOTAL) maze_data = '1;
        if (p == FRAME + 70 * H_TOTAL + 20) maze_valid = 1'b1;
`ifdef MAZE_CURSOR_EN
        if (p == 60 * H_TOTAL) begin cursor_x = 6'd9; cursor_y = 6'd40; end
        if (p == FRAME + 75 * H_TOTAL) begin cursor_x = 6'd20; cursor_y = 6'd50; end
`endif
      end
    end
    n_checks++;
    if (fs_n !== 2) begin n_fail++; $display("[TB] FAIL frame_start_count got=%0d exp=2", fs_n); end
    n_checks++;
    if (fs_c0 !== 2) begin n_fail++; $display("[TB] FAIL first_frame_start got=%0d exp=2", fs_c0); end
    n_checks++;
    if (fs_c1 - fs_c0 !== FRAME) begin n_fail++; $display("[TB] FAIL frame_period got=%0d exp=%0d", fs_c1 - fs_c0, FRAME); end
    n_checks++;
    if (hs_low !== H_SYNC) begin n_fail++; $display("[TB] FAIL hsync_width got=%0d exp=%0d", hs_low, H_SYNC); end
    n_checks++;
    if (hs_first !== H_VIS + H_FP) begin n_fail++; $display("[TB] FAIL hsync_start got=%0d exp=%0d", hs_first, H_VIS + H_FP); end
    n_checks++;
    if (vs_low !== V_SYNC * H_TOTAL) begin n_fail++; $display("[TB] FAIL vsync_width got=%0d exp=%0d", vs_low, V_SYNC * H_TOTAL); end
    n_checks++;
    if (vs_first !== V_VIS + V_FP || vs_last !== V_VIS + V_FP + V_SYNC - 1) begin
      n_fail++;
      $display("[TB] FAIL vsync_lines got=%0d..%0d exp=%0d..%0d", vs_first, vs_last, V_VIS + V_FP, V_VIS + V_FP + V_SYNC - 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int target;
    logic [5:0] got, exp;
    $display("[TB] reset during line 50");
    target = 2 * FRAME + 50 * H_TOTAL + 17 + 2;
    while (cyc < target) begin
      @(negedge clk);
      exp = model_out(cyc, snap2_data, snap2_valid, mcur_x, mcur_y);
      got = {rgb, hsync, vsync, frame_start};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL pre_reset cyc=%0d got=%b exp=%b", cyc, got, exp); end
    end
    reset = 1'b1;
    maze_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {rgb, hsync, vsync, frame_start};
      n_checks++;
      if (got !== 6'b000_110) begin n_fail++; $display("[TB] FAIL reset_hold clk=%0d got=%b exp=000110", i, got); end
    end
    reset = 1'b0;
    for (int i = 0; i < 12 * H_TOTAL; i++) begin
      @(negedge clk);
      exp = model_out(cyc, snap2_data, snap2_valid, mcur_x, mcur_y);
      got = {rgb, hsync, vsync, frame_start};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL post_reset cyc=%0d got=%b exp=%b", cyc, got, exp); end
      if (i == 0 || i == 1) begin
        n_checks++;
        if (frame_start !== (i == 1)) begin
          n_fail++;
          $display("[TB] FAIL restart_frame_start clk=%0d got=%b exp=%b", i + 1, frame_start, (i == 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
